// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register write arbiter.
package shared_reg_arbiter_pkg;

    // Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    // Round-robin pointer width: clog2(n), never less than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dflipflop_en.sv
// Single-bit storage cell with load enable and no reset.
module dflipflop_en (
    input  logic clk,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    logic [PTR_W-1:0] j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = PTR_W'((32'(ptr) + k) % N_REQ);
            if (!valid && req[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin req/ack write arbiter in front of one shared WIDTH-bit register.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   busy
);

    localparam int unsigned PTR_W = ptr_width(N_REQ);

    state_t           state;
    state_t           state_nx;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_nx;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] win_nx;
    logic [PTR_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             pick_valid;
    logic [N_REQ-1:0] grant_nx;
    logic [N_REQ-1:0] ack_nx;
    logic             busy_nx;
    logic             st_en;
    logic [WIDTH-1:0] st_d;
    logic [WIDTH-1:0] sel_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE:  state_nx = pick_valid ? ST_WRITE : ST_IDLE;
            ST_WRITE: state_nx = ST_ACK;
            ST_ACK:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Winner data select, driven from the latched winner index
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win == PTR_W'(i)) begin
                sel_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output logic: next values of the registered outputs plus storage controls
    always_comb begin
        grant_nx  = '0;
        ack_nx    = '0;
        win_nx    = win;
        rr_ptr_nx = rr_ptr;
        st_en     = 1'b0;
        st_d      = sel_data;
        busy_nx   = (state_nx != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_nx = pick_onehot;
                    win_nx   = pick_idx;
                end
            end
            ST_WRITE: begin
                grant_nx = grant;
                ack_nx   = grant;
                st_en    = 1'b1;
            end
            ST_ACK: begin
                rr_ptr_nx = (32'(win) == N_REQ - 1) ? '0 : win + PTR_W'(1);
            end
            default: ;
        endcase
        // Storage has no reset of its own; clear it through the load path.
        if (reset) begin
            st_en = 1'b1;
            st_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant  <= '0;
            ack    <= '0;
            busy   <= 1'b0;
            rr_ptr <= '0;
            win    <= '0;
        end else begin
            grant  <= grant_nx;
            ack    <= ack_nx;
            busy   <= busy_nx;
            rr_ptr <= rr_ptr_nx;
            win    <= win_nx;
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_store
        dflipflop_en u_bit (
            .clk (clk),
            .en  (st_en),
            .d   (st_d[b]),
            .q   (q[b])
        );
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: per-cycle vector table plus corner-case sequences.
module tb_shared_reg_arbiter;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] wd;
        logic [3:0]  g;
        logic [3:0]  a;
        logic [7:0]  q;
        logic        b;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;
    vec_t vq[$];

    shared_reg_arbiter #(
        .N_REQ (4),
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
        .grant (grant),
        .ack   (ack),
        .q     (q),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [31:0] wd,
                                input logic [3:0] g, input logic [3:0] a, input logic [7:0] qq,
                                input logic b);
        vec_t v;
        v.rst = rst; v.req = r; v.wd = wd; v.g = g; v.a = a; v.q = qq; v.b = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] a,
                             input logic [7:0] qq, input logic b);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".ack"},   32'(ack),   32'(a));
        check({tag, ".q"},     32'(q),     32'(qq));
        check({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    // Structural invariants every cycle once out of initial reset
    always @(negedge clk) begin
        if (mon_en) begin
            check("inv_grant_onehot0", 32'($onehot0(grant)), 32'd1);
            check("inv_ack_in_grant",  32'(ack & ~grant),    32'd0);
        end
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        wdata = '0;

        // Reset, single request, contention rotation, wrap/fairness, idle data change
        vq.push_back(mk(1, 4'h0, 32'h00000000, 4'h0, 4'h0, 8'h00, 0));
        vq.push_back(mk(1, 4'h0, 32'h00000000, 4'h0, 4'h0, 8'h00, 0));
        vq.push_back(mk(0, 4'h2, 32'h0000A500, 4'h2, 4'h0, 8'h00, 1));
        vq.push_back(mk(0, 4'h2, 32'h0000A500, 4'h2, 4'h2, 8'hA5, 1));
        vq.push_back(mk(0, 4'h0, 32'h0000A500, 4'h0, 4'h0, 8'hA5, 0));
        vq.push_back(mk(1, 4'h0, 32'h00000000, 4'h0, 4'h0, 8'h00, 0));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h1, 4'h0, 8'h00, 1));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h1, 4'h1, 8'h11, 1));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h0, 4'h0, 8'h11, 0));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h2, 4'h0, 8'h11, 1));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h2, 4'h2, 8'h22, 1));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h0, 4'h0, 8'h22, 0));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h4, 4'h0, 8'h22, 1));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h4, 4'h4, 8'h33, 1));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h0, 4'h0, 8'h33, 0));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h8, 4'h0, 8'h33, 1));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h8, 4'h8, 8'h44, 1));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h0, 4'h0, 8'h44, 0));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h1, 4'h0, 8'h44, 1));
        vq.push_back(mk(0, 4'hF, 32'h44332211, 4'h1, 4'h1, 8'h11, 1));
        vq.push_back(mk(0, 4'h0, 32'h44332211, 4'h0, 4'h0, 8'h11, 0));
        vq.push_back(mk(0, 4'h9, 32'h99000088, 4'h8, 4'h0, 8'h11, 1));
        vq.push_back(mk(0, 4'h9, 32'h99000088, 4'h8, 4'h8, 8'h99, 1));
        vq.push_back(mk(0, 4'h9, 32'h99000088, 4'h0, 4'h0, 8'h99, 0));
        vq.push_back(mk(0, 4'h9, 32'h99000088, 4'h1, 4'h0, 8'h99, 1));
        vq.push_back(mk(0, 4'h9, 32'h99000088, 4'h1, 4'h1, 8'h88, 1));
        vq.push_back(mk(0, 4'h0, 32'h99000088, 4'h0, 4'h0, 8'h88, 0));
        vq.push_back(mk(0, 4'h0, 32'hFFFFFFFF, 4'h0, 4'h0, 8'h88, 0));

        foreach (vq[i]) begin
            reset = vq[i].rst;
            req   = vq[i].req;
            wdata = vq[i].wd;
            step();
            if (i == 1) mon_en = 1'b1;
            check_all($sformatf("vec%0d", i), vq[i].g, vq[i].a, vq[i].q, vq[i].b);
        end

        // Reset during WRITE: no ack, grant cleared, q cleared, pointer back to 0
        req   = 4'b0100;
        wdata = 32'h00FF0000;
        step();
        check_all("rst_mid.write", 4'h4, 4'h0, 8'h88, 1'b1);
        reset = 1'b1;
        step();
        check_all("rst_mid.reset", 4'h0, 4'h0, 8'h00, 1'b0);
        reset = 1'b0;
        req   = 4'b0000;
        step();
        check_all("rst_mid.noack", 4'h0, 4'h0, 8'h00, 1'b0);
        req   = 4'b1111;
        wdata = 32'h44332211;
        step();
        check_all("rst_mid.ptr0", 4'h1, 4'h0, 8'h00, 1'b1);
        req = 4'b0000;
        step();
        check_all("rst_mid.ack0", 4'h1, 4'h1, 8'h11, 1'b1);
        step();
        check_all("rst_mid.idle", 4'h0, 4'h0, 8'h11, 1'b0);

        // Withdrawal of the winner during WRITE still completes the write
        req   = 4'b0100;
        wdata = 32'h005A0000;
        step();
        check_all("wdraw.write", 4'h4, 4'h0, 8'h11, 1'b1);
        req = 4'b0000;
        step();
        check_all("wdraw.ack", 4'h4, 4'h4, 8'h5A, 1'b1);
        step();
        check_all("wdraw.idle", 4'h0, 4'h0, 8'h5A, 1'b0);

        mon_en = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
